// File: rtl/sdram_rom_arbiter_pkg.sv
// Shared types and constants for the SDRAM ROM-port arbiter.
package rom_arb_pkg;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
    typedef enum logic [1:0] {RQ_NONE, RQ_DL, RQ_SND, RQ_CPU} req_id_t;

    localparam logic [22:0] CPU_BASE_DEF = 23'h000000;
    localparam logic [22:0] SND_BASE_DEF = 23'h004000;

    localparam int ERR_DL_OVR  = 0;
    localparam int ERR_ACK_TMO = 1;

    // Byte enables for a single download byte: odd address lands in the high lane.
    function automatic logic [1:0] dl_ds(input logic a0);
        return {a0, ~a0};
    endfunction

endpackage

// File: rtl/sdram_rom_arbiter_if.sv
// Toggle-handshake ROM port between the arbiter (master) and the sdram controller (slave).
interface sdram_rom_arbiter_if;
    logic        port_req;
    logic        port_ack;
    logic [22:0] port_a;
    logic [1:0]  port_ds;
    logic        port_we;
    logic [15:0] port_d;
    logic [15:0] port_q;

    modport master (output port_req, port_a, port_ds, port_we, port_d,
                    input  port_ack, port_q);
    modport slave  (input  port_req, port_a, port_ds, port_we, port_d,
                    output port_ack, port_q);
endinterface

// File: rtl/sdram_rom_arbiter_sync_edge.sv
// Two-flop synchronizer with a registered one-cycle rising-edge pulse.
module sync_edge (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic pulse_o
);
    logic meta_q, sync_q, prev_q, pulse_q;

    // Synchronize the asynchronous level and detect its rising edge.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q  <= 1'b0;
            sync_q  <= 1'b0;
            prev_q  <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            meta_q  <= d_i;
            sync_q  <= meta_q;
            prev_q  <= sync_q;
            pulse_q <= sync_q & ~prev_q;
        end
    end

    assign pulse_o = pulse_q;
endmodule

// File: rtl/sdram_rom_arbiter.sv
// Shares the SDRAM ROM port among download writes, sound-CPU fetch and main-CPU fetch,
// with a one-word hit register per reader.
module sdram_rom_arbiter
    import rom_arb_pkg::*;
#(
    parameter logic [22:0] CPU_BASE = CPU_BASE_DEF,
    parameter logic [22:0] SND_BASE = SND_BASE_DEF,
    parameter int unsigned ACK_TMO  = 255
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic        dl_active,
    input  logic        dl_wr,
    input  logic [24:0] dl_addr,
    input  logic [7:0]  dl_data,
    input  logic        cpu_rd,
    input  logic [14:0] cpu_addr,
    output logic [15:0] cpu_q,
    output logic        cpu_valid,
    input  logic        snd_vma,
    input  logic [12:0] snd_addr,
    output logic [15:0] snd_q,
    output logic        snd_valid,
    output logic        rom_loaded,
    output logic [1:0]  err_flags,
    sdram_rom_arbiter_if.master sd
);
    localparam logic [7:0] TMO_LAST = 8'(ACK_TMO - 1);

    state_t      state_q;
    req_id_t     rid_q, gnt_d;
    logic [22:0] cap_q, cap_d;
    logic        dl_pend_q, dl_wr_prev_q, dl_act_prev_q;
    logic [23:0] dl_a_q;
    logic [7:0]  dl_byte_q;
    logic        snd_pend_q, snd_edge;
    logic [11:0] snd_w_q, snd_tag_q;
    logic        snd_tv_q, cpu_tv_q, snd_hit_d, cpu_hit_d;
    logic [13:0] cpu_tag_q;
    logic [15:0] cpu_data_q, snd_data_q;
    logic        cpu_valid_q, snd_valid_q, rom_loaded_q;
    logic [1:0]  err_q;
    logic [7:0]  tmo_cnt_q;
    logic        port_req_q, port_we_q;
    logic [22:0] port_a_q;
    logic [1:0]  port_ds_q;
    logic [15:0] port_d_q;
    logic        addr_unused;

    assign addr_unused = dl_addr[24] ^ cpu_addr[0] ^ snd_addr[0];

    sync_edge u_snd_sync (
        .clk_i   (clk_sys),
        .rst_ni  (reset_n),
        .d_i     (snd_vma),
        .pulse_o (snd_edge)
    );

    // Grant selection and hit checks; dl > snd > cpu, readers blocked during download.
    always_comb begin
        gnt_d     = RQ_NONE;
        cap_d     = 23'd0;
        snd_hit_d = 1'b0;
        cpu_hit_d = 1'b0;
        if (dl_pend_q) begin
            gnt_d = RQ_DL;
            cap_d = dl_a_q[23:1];
        end else if (dl_active) begin
            gnt_d = RQ_NONE;
        end else if (snd_pend_q) begin
            if (snd_tv_q && (snd_tag_q == snd_w_q)) begin
                snd_hit_d = 1'b1;
            end else begin
                gnt_d = RQ_SND;
                cap_d = {11'd0, snd_w_q};
            end
        end else if (cpu_rd) begin
            if (cpu_tv_q && (cpu_tag_q == cpu_addr[14:1])) begin
                cpu_hit_d = 1'b1;
            end else begin
                gnt_d = RQ_CPU;
                cap_d = {9'd0, cpu_addr[14:1]};
            end
        end else begin
            gnt_d = RQ_NONE;
        end
    end

    // Request capture, transfer FSM, hit registers and sticky status.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            rid_q         <= RQ_NONE;
            cap_q         <= 23'd0;
            dl_pend_q     <= 1'b0;
            dl_wr_prev_q  <= 1'b0;
            dl_act_prev_q <= 1'b0;
            dl_a_q        <= 24'd0;
            dl_byte_q     <= 8'd0;
            snd_pend_q    <= 1'b0;
            snd_w_q       <= 12'd0;
            snd_tag_q     <= 12'd0;
            snd_tv_q      <= 1'b0;
            cpu_tag_q     <= 14'd0;
            cpu_tv_q      <= 1'b0;
            cpu_data_q    <= 16'd0;
            snd_data_q    <= 16'd0;
            cpu_valid_q   <= 1'b0;
            snd_valid_q   <= 1'b0;
            rom_loaded_q  <= 1'b0;
            err_q         <= 2'b00;
            tmo_cnt_q     <= 8'd0;
            port_req_q    <= 1'b0;
            port_we_q     <= 1'b0;
            port_a_q      <= 23'd0;
            port_ds_q     <= 2'b00;
            port_d_q      <= 16'd0;
        end else begin
            cpu_valid_q   <= 1'b0;
            snd_valid_q   <= 1'b0;
            dl_wr_prev_q  <= dl_wr;
            dl_act_prev_q <= dl_active;
            if (dl_act_prev_q && !dl_active) rom_loaded_q <= 1'b1;
            // A second byte before the first is written is dropped and flagged.
            if (dl_wr && !dl_wr_prev_q) begin
                if (dl_pend_q) begin
                    err_q[ERR_DL_OVR] <= 1'b1;
                end else begin
                    dl_pend_q <= 1'b1;
                    dl_a_q    <= dl_addr[23:0];
                    dl_byte_q <= dl_data;
                end
            end
            case (state_q)
                IDLE: begin
                    if (gnt_d != RQ_NONE) begin
                        rid_q   <= gnt_d;
                        cap_q   <= cap_d;
                        state_q <= ISSUE;
                        if (gnt_d == RQ_SND) snd_pend_q <= 1'b0;
                    end else if (snd_hit_d) begin
                        snd_valid_q <= 1'b1;
                        snd_pend_q  <= 1'b0;
                    end else if (cpu_hit_d) begin
                        cpu_valid_q <= 1'b1;
                    end
                end
                ISSUE: begin
                    case (rid_q)
                        RQ_CPU:  port_a_q <= CPU_BASE + cap_q;
                        RQ_SND:  port_a_q <= SND_BASE + cap_q;
                        default: port_a_q <= cap_q;
                    endcase
                    if (rid_q == RQ_DL) begin
                        port_ds_q <= dl_ds(dl_a_q[0]);
                        port_we_q <= 1'b1;
                        port_d_q  <= {dl_byte_q, dl_byte_q};
                    end else begin
                        port_ds_q <= 2'b11;
                        port_we_q <= 1'b0;
                    end
                    port_req_q <= ~port_req_q;
                    tmo_cnt_q  <= 8'd0;
                    state_q    <= WAIT;
                end
                WAIT: begin
                    if (sd.port_ack == port_req_q) begin
                        case (rid_q)
                            RQ_DL:  dl_pend_q <= 1'b0;
                            RQ_CPU: begin
                                cpu_data_q <= sd.port_q;
                                cpu_tag_q  <= cap_q[13:0];
                                cpu_tv_q   <= 1'b1;
                            end
                            RQ_SND: begin
                                snd_data_q <= sd.port_q;
                                snd_tag_q  <= cap_q[11:0];
                                snd_tv_q   <= 1'b1;
                            end
                            default: ;
                        endcase
                        state_q <= DONE;
                    end else if (tmo_cnt_q == TMO_LAST) begin
                        err_q[ERR_ACK_TMO] <= 1'b1;
                    end else begin
                        tmo_cnt_q <= tmo_cnt_q + 8'd1;
                    end
                end
                DONE: begin
                    if (!dl_active) begin
                        cpu_valid_q <= (rid_q == RQ_CPU);
                        snd_valid_q <= (rid_q == RQ_SND);
                    end
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
            if (snd_edge && !dl_active) begin
                snd_pend_q <= 1'b1;
                snd_w_q    <= snd_addr[12:1];
            end
            if (dl_active) begin
                cpu_tv_q <= 1'b0;
                snd_tv_q <= 1'b0;
            end
        end
    end

    assign cpu_q       = cpu_data_q;
    assign cpu_valid   = cpu_valid_q;
    assign snd_q       = snd_data_q;
    assign snd_valid   = snd_valid_q;
    assign rom_loaded  = rom_loaded_q;
    assign err_flags   = err_q;
    assign sd.port_req = port_req_q;
    assign sd.port_a   = port_a_q;
    assign sd.port_ds  = port_ds_q;
    assign sd.port_we  = port_we_q;
    assign sd.port_d   = port_d_q;
endmodule

// File: tb/tb_sdram_rom_arbiter.sv
// Scoreboard bench: byte-level ROM model, per-reader one-word cache model and a behavioural SDRAM.
module tb_sdram_rom_arbiter;
    localparam logic [22:0] CPU_BASE_W = 23'h000000;
    localparam logic [22:0] SND_BASE_W = 23'h004000;

    logic        clk_sys = 1'b0;
    logic        reset_n, dl_active, dl_wr, cpu_rd, snd_vma;
    logic [24:0] dl_addr;
    logic [7:0]  dl_data;
    logic [14:0] cpu_addr;
    logic [12:0] snd_addr;
    logic [15:0] cpu_q, snd_q;
    logic        cpu_valid, snd_valid, rom_loaded;
    logic [1:0]  err_flags;

    always #5 clk_sys = ~clk_sys;

    sdram_rom_arbiter_if sd();

    sdram_rom_arbiter dut (
        .clk_sys(clk_sys), .reset_n(reset_n), .dl_active(dl_active), .dl_wr(dl_wr),
        .dl_addr(dl_addr), .dl_data(dl_data), .cpu_rd(cpu_rd), .cpu_addr(cpu_addr),
        .cpu_q(cpu_q), .cpu_valid(cpu_valid), .snd_vma(snd_vma), .snd_addr(snd_addr),
        .snd_q(snd_q), .snd_valid(snd_valid), .rom_loaded(rom_loaded),
        .err_flags(err_flags), .sd(sd)
    );

    typedef struct {
        logic        we;
        logic [22:0] a;
        logic [1:0]  ds;
        logic [15:0] d;
    } port_t;

    int          n_cmp = 0, n_bad = 0;
    port_t       exp_port[$];
    logic [15:0] exp_cpu[$], exp_snd[$];
    logic [15:0] sd_mem[int];
    logic [7:0]  ref_byte[int];
    int          ack_delay = 2, req_count = 0, done_count = 0;
    bit          cpu_cv = 0, snd_cv = 0;
    int          cpu_cw = 0, snd_cw = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string msg);
        n_cmp++;
        n_bad++;
        $display("FAIL %s (t=%0t)", msg, $time);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk_sys);
    endtask

    // Behavioural SDRAM: one transfer at a time, ack after ack_delay cycles.
    initial begin
        port_t cur;
        port_t e;
        int cnt;
        bit busy;
        logic [15:0] w;
        busy = 0; cnt = 0;
        sd.port_ack = 1'b0;
        sd.port_q = 16'h0;
        forever begin
            @(negedge clk_sys);
            if (!reset_n) begin
                busy = 0;
                sd.port_ack = 1'b0;
            end else if (busy) begin
                if (cnt > 0) cnt--;
                else begin
                    if (cur.we) begin
                        w = sd_mem.exists(int'(cur.a)) ? sd_mem[int'(cur.a)] : 16'h0;
                        if (cur.ds[0]) w[7:0] = cur.d[7:0];
                        if (cur.ds[1]) w[15:8] = cur.d[15:8];
                        sd_mem[int'(cur.a)] = w;
                    end else begin
                        sd.port_q = sd_mem.exists(int'(cur.a)) ? sd_mem[int'(cur.a)] : 16'hDEAD;
                    end
                    sd.port_ack = ~sd.port_ack;
                    busy = 0;
                    done_count++;
                end
            end else if (sd.port_req !== sd.port_ack) begin
                cur.we = sd.port_we; cur.a = sd.port_a; cur.ds = sd.port_ds; cur.d = sd.port_d;
                req_count++;
                if (exp_port.size() == 0) begin
                    fail_now($sformatf("port_unexpected got we=%b a=%h, expected no access", cur.we, cur.a));
                end else begin
                    e = exp_port.pop_front();
                    check("port_txn", {cur.we, cur.a, cur.ds, cur.we ? cur.d : 16'h0},
                                      {e.we, e.a, e.ds, e.we ? e.d : 16'h0});
                end
                busy = 1;
                cnt = ack_delay;
            end
        end
    end

    // Monitor: every valid pulse pops the oldest expected word for that reader.
    initial begin
        forever begin
            @(negedge clk_sys);
            if (reset_n === 1'b1) begin
                if (cpu_valid) begin
                    if (exp_cpu.size() == 0) fail_now($sformatf("cpu_valid_unexpected got q=%h, expected none", cpu_q));
                    else check("cpu_q", cpu_q, exp_cpu.pop_front());
                end
                if (snd_valid) begin
                    if (exp_snd.size() == 0) fail_now($sformatf("snd_valid_unexpected got q=%h, expected none", snd_q));
                    else check("snd_q", snd_q, exp_snd.pop_front());
                end
            end
        end
    end

    task automatic dl_byte(input int addr, input logic [7:0] data);
        port_t e;
        int d0;
        e.we = 1'b1; e.a = 23'(addr >> 1); e.ds = addr[0] ? 2'b10 : 2'b01; e.d = {data, data};
        exp_port.push_back(e);
        ref_byte[addr] = data;
        d0 = done_count;
        dl_addr = 25'(addr); dl_data = data; dl_wr = 1'b1;
        tick(1);
        dl_wr = 1'b0;
        for (int i = 0; i < 1000 && done_count == d0; i++) tick(1);
        if (done_count == d0) fail_now($sformatf("dl_timeout addr=%h got no ack, expected write", addr));
        tick(2);
    endtask

    task automatic cpu_fetch(input int addr, input bit chk);
        port_t e;
        int w, rc0, cyc;
        bit hit, got;
        w = addr >> 1;
        hit = cpu_cv && (cpu_cw == w);
        exp_cpu.push_back({ref_byte[2*w+1], ref_byte[2*w]});
        if (!hit) begin
            e.we = 1'b0; e.a = CPU_BASE_W + 23'(w); e.ds = 2'b11; e.d = 16'h0;
            exp_port.push_back(e);
        end
        cpu_cv = 1; cpu_cw = w;
        rc0 = req_count; cyc = 0; got = 0;
        cpu_addr = 15'(addr); cpu_rd = 1'b1;
        while (!got && cyc < 1000) begin
            tick(1); cyc++;
            if (cpu_valid) got = 1;
        end
        cpu_rd = 1'b0;
        if (!got) fail_now($sformatf("cpu_timeout addr=%h got no cpu_valid, expected one", addr));
        if (chk) begin
            check("cpu_sdram_reads", 64'(req_count - rc0), hit ? 64'd0 : 64'd1);
            if (hit) check("cpu_hit_latency", 64'(cyc), 64'd1);
        end
    endtask

    task automatic snd_fetch(input int addr, input bit chk);
        port_t e;
        int w, rc0, cyc;
        bit hit, got;
        w = addr >> 1;
        hit = snd_cv && (snd_cw == w);
        exp_snd.push_back({ref_byte[32'h8000 + 2*w + 1], ref_byte[32'h8000 + 2*w]});
        if (!hit) begin
            e.we = 1'b0; e.a = SND_BASE_W + 23'(w); e.ds = 2'b11; e.d = 16'h0;
            exp_port.push_back(e);
        end
        snd_cv = 1; snd_cw = w;
        rc0 = req_count; cyc = 0; got = 0;
        snd_addr = 13'(addr); snd_vma = 1'b1;
        while ((!got || cyc < 4) && cyc < 1000) begin
            if (cyc == 4) snd_vma = 1'b0;
            tick(1); cyc++;
            if (snd_valid) got = 1;
        end
        snd_vma = 1'b0;
        if (!got) fail_now($sformatf("snd_timeout addr=%h got no snd_valid, expected one", addr));
        if (chk) check("snd_sdram_reads", 64'(req_count - rc0), hit ? 64'd0 : 64'd1);
        tick(3);
    endtask

    task automatic check_all_zero(input string nm);
        check({nm, "_outs"}, {cpu_q, snd_q, cpu_valid, snd_valid, rom_loaded, err_flags}, 64'd0);
        check({nm, "_port"}, {sd.port_req, sd.port_a, sd.port_ds, sd.port_we, sd.port_d}, 64'd0);
    endtask

    initial begin
        #(5_000_000);
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        port_t e;
        int r0, d0, a, last_cpu;
        logic [7:0] v;
        reset_n = 1'b0; dl_active = 1'b0; dl_wr = 1'b0; dl_addr = 25'd0; dl_data = 8'd0;
        cpu_rd = 1'b0; cpu_addr = 15'd0; snd_vma = 1'b0; snd_addr = 13'd0;
        tick(3);
        check_all_zero("reset");
        reset_n = 1'b1;
        tick(2);

        // 16-byte download, ack 3 cycles later
        ack_delay = 3;
        dl_active = 1'b1;
        for (int i = 0; i < 16; i++) dl_byte(i, 8'($urandom));
        check("rom_loaded_early", rom_loaded, 1'b0);
        dl_active = 1'b0; cpu_cv = 0; snd_cv = 0;
        tick(2);
        check("rom_loaded", rom_loaded, 1'b1);

        // rest of the CPU image and the sound image
        dl_active = 1'b1;
        for (int i = 16; i < 512; i++) begin
            ack_delay = $urandom_range(0, 3);
            dl_byte(i, 8'($urandom));
        end
        for (int i = 0; i < 64; i++) dl_byte(32'h8000 + i, 8'($urandom));
        dl_active = 1'b0; cpu_cv = 0; snd_cv = 0;
        tick(2);

        // miss then same-word hit
        ack_delay = 2;
        cpu_fetch(32'h12, 1);
        cpu_fetch(32'h13, 1);

        last_cpu = 32'h13;
        for (int i = 0; i < 40; i++) begin
            ack_delay = $urandom_range(0, 6);
            if ($urandom_range(0, 1) == 1) begin
                a = ($urandom_range(0, 2) == 0) ? (last_cpu ^ 1) : $urandom_range(0, 511);
                cpu_fetch(a, 1);
                last_cpu = a;
            end else begin
                snd_fetch($urandom_range(0, 63), 1);
            end
        end

        // snd edge during a cpu transfer is served before the next cpu miss
        snd_fetch(16, 1);
        cpu_fetch(32'h1F0, 1);
        ack_delay = 20;
        fork
            begin
                cpu_fetch(32'h40, 0);
                cpu_fetch(32'h100, 0);
            end
            begin
                r0 = req_count;
                for (int i = 0; i < 200 && req_count == r0; i++) tick(1);
                tick(2);
                snd_fetch(4, 0);
            end
        join

        // download overrun: second edge while the first write is outstanding
        ack_delay = 10;
        dl_active = 1'b1;
        v = 8'($urandom);
        e.we = 1'b1; e.a = 23'h10; e.ds = 2'b01; e.d = {v, v};
        exp_port.push_back(e);
        ref_byte[32'h20] = v;
        r0 = req_count; d0 = done_count;
        dl_addr = 25'h20; dl_data = v; dl_wr = 1'b1;
        tick(1); dl_wr = 1'b0; tick(1);
        dl_addr = 25'h21; dl_data = ~v; dl_wr = 1'b1;
        tick(1); dl_wr = 1'b0;
        for (int i = 0; i < 1000 && done_count == d0; i++) tick(1);
        tick(20);
        check("dl_overrun_writes", 64'(req_count - r0), 64'd1);
        dl_active = 1'b0; cpu_cv = 0; snd_cv = 0;
        tick(2);
        check("err_overrun", err_flags, 2'b01);
        ack_delay = 1;
        cpu_fetch(32'h20, 1);

        // ack timeout is flagged but the transfer still completes
        ack_delay = 300;
        fork
            cpu_fetch(32'h150, 1);
            begin
                tick(200);
                check("tmo_not_yet", err_flags[1], 1'b0);
                tick(90);
                check("tmo_set", err_flags[1], 1'b1);
            end
        join
        check("err_both", err_flags, 2'b11);

        // reset during WAIT abandons the transfer and clears the hit registers
        ack_delay = 2;
        cpu_fetch(32'h60, 1);
        ack_delay = 20;
        e.we = 1'b0; e.a = CPU_BASE_W + 23'h38; e.ds = 2'b11; e.d = 16'h0;
        exp_port.push_back(e);
        cpu_addr = 15'h70; cpu_rd = 1'b1;
        tick(8);
        #2;
        reset_n = 1'b0; cpu_rd = 1'b0;
        #1;
        check_all_zero("midreset");
        tick(2);
        reset_n = 1'b1;
        cpu_cv = 0; snd_cv = 0;
        tick(2);
        ack_delay = 2;
        cpu_fetch(32'h60, 1);
        snd_fetch(4, 1);

        ack_delay = 0;
        tick(5);
        check("exp_port_left", 64'(exp_port.size()), 64'd0);
        check("exp_cpu_left", 64'(exp_cpu.size()), 64'd0);
        check("exp_snd_left", 64'(exp_snd.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
